// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: keeps up to MAX_OUTSTANDING requests in flight on the
// sram-like bus and queues returned instructions in an IBUF_DEPTH-entry buffer ahead of ID.
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC        = 32'h1c000000,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned IBUF_DEPTH      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        fetch_stall,
  output logic        req,
  output logic        wr,
  output logic [1:0]  size,
  output logic [31:0] addr,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  input  logic        addr_ok,
  input  logic        data_ok,
  input  logic [31:0] rdata,
  input  logic [5:0]  mmu_ecode_i,
  input  logic [8:0]  mmu_esubcode_i,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_has_exc,
  output logic [5:0]  out_ecode,
  output logic [8:0]  out_esubcode
);

  localparam int unsigned CW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned BW  = $clog2(IBUF_DEPTH + 1);
  localparam int unsigned MPW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned IPW = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;

  logic [31:0]    r_fetch_pc;
  logic           r_halted;
  logic [CW-1:0]  r_inflight;
  logic [CW-1:0]  r_discard_cnt;
  logic [BW-1:0]  r_ibuf_cnt;
  logic [MPW-1:0] r_mwr_ptr, r_mrd_ptr;
  logic [IPW-1:0] r_iwr_ptr, r_ird_ptr;

  logic [31:0] r_meta_pc [MAX_OUTSTANDING];
  logic [31:0] r_ib_pc   [IBUF_DEPTH];
  logic [31:0] r_ib_inst [IBUF_DEPTH];
  logic        r_ib_exc  [IBUF_DEPTH];
  logic [5:0]  r_ib_ec   [IBUF_DEPTH];
  logic [8:0]  r_ib_esub [IBUF_DEPTH];

  logic           w_adef, w_exc_now, w_credit_ok, w_req, w_accept, w_exc_wr;
  logic           w_resp_drop, w_resp_take, w_push, w_pop, w_out_valid, w_ibuf_full;
  logic [5:0]     w_exc_ecode;
  logic [8:0]     w_exc_esub;
  logic [31:0]    w_push_pc, w_push_inst;
  logic [CW-1:0]  w_inflight_d, w_discard_d;
  logic [BW-1:0]  w_ibuf_cnt_d;
  logic [MPW-1:0] w_mwr_inc, w_mrd_inc;
  logic [IPW-1:0] w_iwr_inc, w_ird_inc;

  always_comb begin
    w_adef      = r_fetch_pc[1:0] != 2'b00;
    w_exc_now   = w_adef || (mmu_ecode_i != 6'h00);
    w_exc_ecode = w_adef ? 6'h08 : mmu_ecode_i;
    w_exc_esub  = w_adef ? 9'h000 : mmu_esubcode_i;
    w_ibuf_full = r_ibuf_cnt == BW'(IBUF_DEPTH);
    w_out_valid = r_ibuf_cnt != '0;
    // Credits are judged on registered counts only; same-cycle returns do not count.
    w_credit_ok = ((32'(r_inflight) + 32'(r_discard_cnt)) < MAX_OUTSTANDING) &&
                  ((32'(r_inflight) + 32'(r_ibuf_cnt)) < IBUF_DEPTH);
    w_req       = !rst && !redirect && !r_halted && !fetch_stall && w_credit_ok && !w_exc_now;
    w_accept    = w_req && addr_ok;
    w_exc_wr    = w_exc_now && !r_halted && !redirect && (r_inflight == '0) && !w_ibuf_full;
    w_resp_drop = data_ok && (r_discard_cnt != '0);
    w_resp_take = data_ok && (r_discard_cnt == '0) && (r_inflight != '0);
    w_push      = !redirect && (w_resp_take || w_exc_wr);
    w_pop       = !redirect && w_out_valid && out_ready;
    w_push_pc   = w_exc_wr ? r_fetch_pc : r_meta_pc[r_mrd_ptr];
    w_push_inst = w_exc_wr ? 32'h0 : rdata;

    w_mwr_inc = (r_mwr_ptr == MPW'(MAX_OUTSTANDING - 1)) ? '0 : r_mwr_ptr + MPW'(1);
    w_mrd_inc = (r_mrd_ptr == MPW'(MAX_OUTSTANDING - 1)) ? '0 : r_mrd_ptr + MPW'(1);
    w_iwr_inc = (r_iwr_ptr == IPW'(IBUF_DEPTH - 1)) ? '0 : r_iwr_ptr + IPW'(1);
    w_ird_inc = (r_ird_ptr == IPW'(IBUF_DEPTH - 1)) ? '0 : r_ird_ptr + IPW'(1);

    w_inflight_d = r_inflight;
    if (w_accept)    w_inflight_d = w_inflight_d + CW'(1);
    if (w_resp_take) w_inflight_d = w_inflight_d - CW'(1);

    // On redirect everything still owed becomes stale, minus a response landing this cycle.
    if (redirect) begin
      w_discard_d = r_discard_cnt + r_inflight;
      if (w_resp_take || w_resp_drop) w_discard_d = w_discard_d - CW'(1);
    end else begin
      w_discard_d = r_discard_cnt;
      if (w_resp_drop) w_discard_d = w_discard_d - CW'(1);
    end

    w_ibuf_cnt_d = r_ibuf_cnt;
    if (w_push) w_ibuf_cnt_d = w_ibuf_cnt_d + BW'(1);
    if (w_pop)  w_ibuf_cnt_d = w_ibuf_cnt_d - BW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_halted      <= 1'b0;
      r_inflight    <= '0;
      r_discard_cnt <= '0;
      r_ibuf_cnt    <= '0;
      r_mwr_ptr     <= '0;
      r_mrd_ptr     <= '0;
      r_iwr_ptr     <= '0;
      r_ird_ptr     <= '0;
    end else if (redirect) begin
      r_fetch_pc    <= redirect_pc;
      r_halted      <= 1'b0;
      r_inflight    <= '0;
      r_discard_cnt <= w_discard_d;
      r_ibuf_cnt    <= '0;
      r_mwr_ptr     <= '0;
      r_mrd_ptr     <= '0;
      r_iwr_ptr     <= '0;
      r_ird_ptr     <= '0;
    end else begin
      if (w_accept)    r_fetch_pc <= r_fetch_pc + 32'd4;
      if (w_accept)    r_mwr_ptr  <= w_mwr_inc;
      if (w_resp_take) r_mrd_ptr  <= w_mrd_inc;
      if (w_exc_wr)    r_halted   <= 1'b1;
      if (w_push)      r_iwr_ptr  <= w_iwr_inc;
      if (w_pop)       r_ird_ptr  <= w_ird_inc;
      r_inflight    <= w_inflight_d;
      r_discard_cnt <= w_discard_d;
      r_ibuf_cnt    <= w_ibuf_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_meta_pc[r_mwr_ptr] <= r_fetch_pc;
    if (w_push) begin
      r_ib_pc[r_iwr_ptr]   <= w_push_pc;
      r_ib_inst[r_iwr_ptr] <= w_push_inst;
      r_ib_exc[r_iwr_ptr]  <= w_exc_wr;
      r_ib_ec[r_iwr_ptr]   <= w_exc_wr ? w_exc_ecode : 6'h00;
      r_ib_esub[r_iwr_ptr] <= w_exc_wr ? w_exc_esub : 9'h000;
    end
  end

  always_comb begin
    req          = w_req;
    wr           = 1'b0;
    size         = 2'b10;
    addr         = {r_fetch_pc[31:2], 2'b00};
    wstrb        = 4'h0;
    wdata        = 32'h0;
    out_valid    = w_out_valid;
    out_pc       = w_out_valid ? r_ib_pc[r_ird_ptr]   : 32'h0;
    out_inst     = w_out_valid ? r_ib_inst[r_ird_ptr] : 32'h0;
    out_has_exc  = w_out_valid ? r_ib_exc[r_ird_ptr]  : 1'b0;
    out_ecode    = w_out_valid ? r_ib_ec[r_ird_ptr]   : 6'h00;
    out_esubcode = w_out_valid ? r_ib_esub[r_ird_ptr] : 9'h000;
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed, table-driven bench for if_fetch_queue: one vector per clock cycle with
// hand-computed expectations, plus a hand-written MMU-exception ordering sequence.
module tb_if_fetch_queue;

  localparam logic [31:0] B = 32'h1c000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        fetch_stall = 1'b0;
  logic        req, wr;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic        addr_ok = 1'b0, data_ok = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic [5:0]  mmu_ecode_i = 6'h0;
  logic [8:0]  mmu_esubcode_i = 9'h0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_pc, out_inst;
  logic        out_has_exc;
  logic [5:0]  out_ecode;
  logic [8:0]  out_esubcode;

  int n_assert = 0;
  int n_fail   = 0;
  int tb_out   = 0;

  always #5 clk = ~clk;

  if_fetch_queue #(
    .RESET_PC       (B),
    .MAX_OUTSTANDING(2),
    .IBUF_DEPTH     (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .fetch_stall   (fetch_stall),
    .req           (req),
    .wr            (wr),
    .size          (size),
    .addr          (addr),
    .wstrb         (wstrb),
    .wdata         (wdata),
    .addr_ok       (addr_ok),
    .data_ok       (data_ok),
    .rdata         (rdata),
    .mmu_ecode_i   (mmu_ecode_i),
    .mmu_esubcode_i(mmu_esubcode_i),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_inst      (out_inst),
    .out_has_exc   (out_has_exc),
    .out_ecode     (out_ecode),
    .out_esubcode  (out_esubcode)
  );

  typedef struct {
    bit          rb, redir, stall, aok, dok, rdy;
    logic [31:0] rpc, rdata;
    logic [5:0]  mmu;
    logic [8:0]  msub;
    bit          ereq, eov, eexc;
    logic [31:0] eaddr, epc, einst;
    logic [5:0]  eec;
    logic [8:0]  esub;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rb, bit redir, logic [31:0] rpc, bit stall, bit aok, bit dok,
                              logic [31:0] rd, logic [5:0] mmu, logic [8:0] msub, bit rdy,
                              bit ereq, logic [31:0] eaddr, bit eov, logic [31:0] epc,
                              logic [31:0] einst, bit eexc, logic [5:0] eec, logic [8:0] esub);
    vec_t v;
    v.rb = rb; v.redir = redir; v.rpc = rpc; v.stall = stall; v.aok = aok; v.dok = dok;
    v.rdata = rd; v.mmu = mmu; v.msub = msub; v.rdy = rdy;
    v.ereq = ereq; v.eaddr = eaddr; v.eov = eov; v.epc = epc; v.einst = einst;
    v.eexc = eexc; v.eec = eec; v.esub = esub;
    return v;
  endfunction

  function automatic vec_t nv(bit rb, bit redir, logic [31:0] rpc, bit stall, bit aok, bit dok,
                              logic [31:0] rd, bit rdy, bit ereq, logic [31:0] eaddr, bit eov,
                              logic [31:0] epc, logic [31:0] einst);
    return mk(rb, redir, rpc, stall, aok, dok, rd, 6'h0, 9'h0, rdy,
              ereq, eaddr, eov, epc, einst, 1'b0, 6'h0, 9'h0);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (vector %0d): got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; redirect = 1'b0; fetch_stall = 1'b0; addr_ok = 1'b0; data_ok = 1'b0;
    mmu_ecode_i = 6'h0; mmu_esubcode_i = 9'h0; out_ready = 1'b0;
    tb_out = 0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    bit acc;
    if (v.rb) do_reset();
    @(negedge clk);
    rst = 1'b0; redirect = v.redir; redirect_pc = v.rpc; fetch_stall = v.stall;
    addr_ok = v.aok; data_ok = v.dok; rdata = v.rdata; mmu_ecode_i = v.mmu;
    mmu_esubcode_i = v.msub; out_ready = v.rdy;
    #1;
    chk("req", idx, {31'b0, req}, {31'b0, v.ereq});
    if (v.ereq) chk("addr", idx, addr, v.eaddr);
    chk("out_valid", idx, {31'b0, out_valid}, {31'b0, v.eov});
    if (v.eov) begin
      chk("out_pc", idx, out_pc, v.epc);
      chk("out_inst", idx, out_inst, v.einst);
      chk("out_has_exc", idx, {31'b0, out_has_exc}, {31'b0, v.eexc});
      chk("out_ecode", idx, {26'b0, out_ecode}, {26'b0, v.eec});
      chk("out_esubcode", idx, {23'b0, out_esubcode}, {23'b0, v.esub});
    end
    // Bus-level outstanding count, independent of redirects: data_ok needs a prior accept.
    if (v.dok) chk("proto_data_ok_owed", idx, {31'b0, tb_out > 0}, 32'd1);
    acc = req && v.aok;
    tb_out = tb_out + (acc ? 1 : 0) - ((v.dok && tb_out > 0) ? 1 : 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", -1, {31'b0, req}, 32'd0);
    chk("rst_out_valid", -1, {31'b0, out_valid}, 32'd0);
    chk("rst_out_pc", -1, out_pc, 32'h0);
    chk("rst_out_inst", -1, out_inst, 32'h0);
    chk("rst_out_has_exc", -1, {31'b0, out_has_exc}, 32'd0);
    chk("rst_out_ecode", -1, {26'b0, out_ecode}, 32'd0);
    chk("rst_out_esubcode", -1, {23'b0, out_esubcode}, 32'd0);
    chk("const_bus", -1, {wr, size, wstrb, 25'b0}, {1'b0, 2'b10, 4'h0, 25'b0});
    chk("const_wdata", -1, wdata, 32'h0);

    // Steady-state streaming, one response per cycle.
    vecs.push_back(nv(1, 0, 0, 0, 1, 0, 0,     1, 1, B + 'h00, 0, 0, 0));
    vecs.push_back(nv(0, 0, 0, 0, 1, 1, 'ha0, 1, 1, B + 'h04, 0, 0, 0));
    vecs.push_back(nv(0, 0, 0, 0, 1, 1, 'ha1, 1, 1, B + 'h08, 1, B + 'h00, 'ha0));
    vecs.push_back(nv(0, 0, 0, 0, 1, 1, 'ha2, 1, 1, B + 'h0c, 1, B + 'h04, 'ha1));
    vecs.push_back(nv(0, 0, 0, 0, 1, 1, 'ha3, 1, 1, B + 'h10, 1, B + 'h08, 'ha2));
    vecs.push_back(nv(0, 0, 0, 0, 0, 1, 'ha4, 1, 1, B + 'h14, 1, B + 'h0c, 'ha3));
    vecs.push_back(nv(0, 0, 0, 0, 0, 0, 0,     1, 1, B + 'h14, 1, B + 'h10, 'ha4));
    vecs.push_back(nv(0, 0, 0, 1, 1, 0, 0,     1, 0, 0, 0, 0, 0));
    // ibuf fills to 4 with ID stalled, then drains in order.
    vecs.push_back(nv(1, 0, 0, 0, 1, 0, 0,     0, 1, B + 'h00, 0, 0, 0));
    vecs.push_back(nv(0, 0, 0, 0, 1, 1, 'hb0, 0, 1, B + 'h04, 0, 0, 0));
    vecs.push_back(nv(0, 0, 0, 0, 1, 1, 'hb1, 0, 1, B + 'h08, 1, B + 'h00, 'hb0));
    vecs.push_back(nv(0, 0, 0, 0, 1, 1, 'hb2, 0, 1, B + 'h0c, 1, B + 'h00, 'hb0));
    vecs.push_back(nv(0, 0, 0, 0, 1, 1, 'hb3, 0, 0, 0, 1, B + 'h00, 'hb0));
    vecs.push_back(nv(0, 0, 0, 0, 1, 0, 0,     0, 0, 0, 1, B + 'h00, 'hb0));
    vecs.push_back(nv(0, 0, 0, 0, 1, 0, 0,     1, 0, 0, 1, B + 'h00, 'hb0));
    vecs.push_back(nv(0, 0, 0, 0, 1, 0, 0,     1, 1, B + 'h10, 1, B + 'h04, 'hb1));
    vecs.push_back(nv(0, 0, 0, 0, 0, 1, 'hb4, 1, 1, B + 'h14, 1, B + 'h08, 'hb2));
    vecs.push_back(nv(0, 0, 0, 0, 0, 0, 0,     1, 1, B + 'h14, 1, B + 'h0c, 'hb3));
    vecs.push_back(nv(0, 0, 0, 0, 0, 0, 0,     1, 1, B + 'h14, 1, B + 'h10, 'hb4));
    vecs.push_back(nv(0, 0, 0, 0, 0, 0, 0,     1, 1, B + 'h14, 0, 0, 0));
    // Redirect with two requests in flight; both stale responses dropped.
    vecs.push_back(nv(1, 0, 0, 0, 1, 0, 0,     1, 1, B + 'h00, 0, 0, 0));
    vecs.push_back(nv(0, 0, 0, 0, 1, 0, 0,     1, 1, B + 'h04, 0, 0, 0));
    vecs.push_back(nv(0, 0, 0, 0, 1, 0, 0,     1, 0, 0, 0, 0, 0));
    vecs.push_back(nv(0, 1, B + 'h100, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(nv(0, 0, 0, 0, 1, 1, 'hdead0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(nv(0, 0, 0, 0, 1, 1, 'hdead1, 1, 1, B + 'h100, 0, 0, 0));
    vecs.push_back(nv(0, 0, 0, 0, 0, 1, 'hc0,  1, 1, B + 'h104, 0, 0, 0));
    vecs.push_back(nv(0, 0, 0, 0, 0, 0, 0,     1, 1, B + 'h104, 1, B + 'h100, 'hc0));
    vecs.push_back(nv(0, 0, 0, 1, 0, 0, 0,     1, 0, 0, 0, 0, 0));
    vecs.push_back(nv(0, 1, B + 'h400, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(nv(0, 0, 0, 1, 0, 0, 0,     1, 0, 0, 0, 0, 0));
    vecs.push_back(nv(0, 0, 0, 0, 0, 0, 0,     1, 1, B + 'h400, 0, 0, 0));
    // Redirect coinciding with a response: that one and the next are dropped.
    vecs.push_back(nv(1, 0, 0, 0, 1, 0, 0,     1, 1, B + 'h00, 0, 0, 0));
    vecs.push_back(nv(0, 0, 0, 0, 1, 0, 0,     1, 1, B + 'h04, 0, 0, 0));
    vecs.push_back(nv(0, 1, B + 'h200, 0, 0, 1, 'hdead, 1, 0, 0, 0, 0, 0));
    vecs.push_back(nv(0, 0, 0, 0, 1, 1, 'hdead2, 1, 1, B + 'h200, 0, 0, 0));
    vecs.push_back(nv(0, 0, 0, 0, 0, 1, 'he0,  1, 1, B + 'h204, 0, 0, 0));
    vecs.push_back(nv(0, 0, 0, 0, 0, 0, 0,     1, 1, B + 'h204, 1, B + 'h200, 'he0));
    // Misaligned redirect target: ADEF entry (wins over MMU), halted until next redirect.
    vecs.push_back(nv(1, 1, B + 'h102, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 6'h05, 9'h007, 0, 0, 0, 0, 0, 0, 0, 6'h0, 9'h0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 6'h0, 9'h0, 0, 0, 0, 1, B + 'h102, 0, 1, 6'h08, 9'h0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 6'h0, 9'h0, 1, 0, 0, 1, B + 'h102, 0, 1, 6'h08, 9'h0));
    vecs.push_back(nv(0, 0, 0, 0, 1, 0, 0,     1, 0, 0, 0, 0, 0));
    vecs.push_back(nv(0, 1, B + 'h300, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(nv(0, 0, 0, 0, 0, 0, 0,     1, 1, B + 'h300, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // MMU fault at 1c000008 while 1c000004 is in flight: fault entry must follow it.
    run_vec(nv(1, 0, 0, 0, 1, 0, 0,     1, 1, B + 'h00, 0, 0, 0), 100);
    run_vec(nv(0, 0, 0, 0, 1, 1, 'hf0, 1, 1, B + 'h04, 0, 0, 0), 101);
    run_vec(mk(0, 0, 0, 0, 1, 0, 0,     6'h03, 9'h005, 1, 0, 0, 1, B + 'h00, 'hf0, 0, 0, 0), 102);
    run_vec(mk(0, 0, 0, 0, 0, 1, 'hf1, 6'h03, 9'h005, 1, 0, 0, 0, 0, 0, 0, 0, 0), 103);
    run_vec(mk(0, 0, 0, 0, 0, 0, 0,     6'h03, 9'h005, 1, 0, 0, 1, B + 'h04, 'hf1, 0, 0, 0), 104);
    run_vec(mk(0, 0, 0, 0, 0, 0, 0,     6'h03, 9'h005, 1, 0, 0, 1, B + 'h08, 0, 1, 6'h03, 9'h005),
            105);
    run_vec(nv(0, 0, 0, 0, 1, 0, 0,     1, 0, 0, 0, 0, 0), 106);
    run_vec(nv(0, 0, 0, 0, 1, 0, 0,     1, 0, 0, 0, 0, 0), 107);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
